fdivsqrt_prenorm_seq: RTL and testbench

Iterative pre-normalizer for the divide/square-root unit. It takes raw significands, which may be subnormal, and shifts each left until its leading bit is set. It counts the shifts to produce the leading-zero counts `ell` (X) and `m` (Y) that the exponent calculation subtracts from Xe/Ye. It sits between the FPU operand unpacker and the div/sqrt iteration datapath, with a start/done handshake.

---
 rtl/fdivsqrt_prenorm_seq.sv | 164 ++++++++++++++++
 tb/tb_fdivsqrt_prenorm_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fdivsqrt_prenorm_seq.sv
// fdivsqrt_prenorm_seq
//
// Iterative pre-normalizer for the divide/square-root unit. Raw significands
// (possibly subnormal) are shifted left until their integer bit is set, and the
// number of positions removed is reported as ell (X) and m (Y) for the exponent
// calculation. Start/done handshake; flush aborts to idle.
//
// Build option: define FDIVSQRT_PRENORM_SHIFT4_EN to step up to 4 positions per
// cycle (priority decode of the top nibble). Results are identical either way;
// only latency changes.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, flush      request (ignored while busy), synchronous abort
//   Sqrt              1 = square root; Ym ignored, Y forced to 1.0
//   Xm, Ym            NF+1 bit significands, MSB is the integer bit
//   busy, done        busy in NORM/DONE; done is a one-cycle result-valid pulse
//   XNorm, YNorm      normalized significands
//   ell, m            leading zeros removed from X / Y
//   XZeroOut, YZeroOut operand was zero (Y never zero for sqrt)
module fdivsqrt_prenorm_seq #(
    parameter int unsigned NF      = 52,
    parameter int unsigned DIVBLEN = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               flush,
    input  logic               Sqrt,
    input  logic [NF:0]        Xm,
    input  logic [NF:0]        Ym,
    output logic               busy,
    output logic               done,
    output logic [NF:0]        XNorm,
    output logic [NF:0]        YNorm,
    output logic [DIVBLEN-1:0] ell,
    output logic [DIVBLEN-1:0] m,
    output logic               XZeroOut,
    output logic               YZeroOut
);

    typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;

    state_e             state_q, state_d;
    logic [NF:0]        x_q, x_d, y_q, y_d;
    logic [DIVBLEN-1:0] ell_q, ell_d, m_q, m_d;
    logic               xz_q, xz_d, yz_q, yz_d;
    logic               sqrt_q, sqrt_d;

    logic               need_x, need_y;
    logic [2:0]         x_step, y_step;

    // Zero operands stay zero under shifting, so the captured flags are enough.
    // For sqrt Y is loaded as 1.0, so its MSB already blocks shifting.
    assign need_x = !x_q[NF] && !xz_q;
    assign need_y = !y_q[NF] && !yz_q && !sqrt_q;

`ifdef FDIVSQRT_PRENORM_SHIFT4_EN
    // Step = leading zeros in the top nibble, capped at 4. Never overshoots the
    // leading one, so the final result matches the 1-bit build.
    always_comb begin
        x_step = 3'd4;
        priority casez (x_q[NF -: 4])
            4'b1???: x_step = 3'd0;
            4'b01??: x_step = 3'd1;
            4'b001?: x_step = 3'd2;
            4'b0001: x_step = 3'd3;
            default: x_step = 3'd4;
        endcase
    end

    always_comb begin
        y_step = 3'd4;
        priority casez (y_q[NF -: 4])
            4'b1???: y_step = 3'd0;
            4'b01??: y_step = 3'd1;
            4'b001?: y_step = 3'd2;
            4'b0001: y_step = 3'd3;
            default: y_step = 3'd4;
        endcase
    end
`else
    assign x_step = 3'd1;
    assign y_step = 3'd1;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ell_d   = ell_q;
        m_d     = m_q;
        xz_d    = xz_q;
        yz_d    = yz_q;
        sqrt_d  = sqrt_q;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    state_d = StNorm;
                    x_d     = Xm;
                    y_d     = Sqrt ? {1'b1, {NF{1'b0}}} : Ym;
                    ell_d   = '0;
                    m_d     = '0;
                    xz_d    = (Xm == '0);
                    yz_d    = !Sqrt && (Ym == '0);
                    sqrt_d  = Sqrt;
                end
            end
            StNorm: begin
                if (need_x) begin
                    x_d   = x_q << x_step;
                    ell_d = ell_q + DIVBLEN'(x_step);
                end
                if (need_y) begin
                    y_d = y_q << y_step;
                    m_d = m_q + DIVBLEN'(y_step);
                end
                if (!need_x && !need_y) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort wins over everything, including a start seen in idle.
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            ell_q   <= '0;
            m_q     <= '0;
            xz_q    <= 1'b0;
            yz_q    <= 1'b0;
            sqrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ell_q   <= ell_d;
            m_q     <= m_d;
            xz_q    <= xz_d;
            yz_q    <= yz_d;
            sqrt_q  <= sqrt_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign XNorm    = x_q;
    assign YNorm    = y_q;
    assign ell      = ell_q;
    assign m        = m_q;
    assign XZeroOut = xz_q;
    assign YZeroOut = yz_q;

endmodule

// File: tb/tb_fdivsqrt_prenorm_seq.sv
// Self-checking bench for fdivsqrt_prenorm_seq (NF=52, DIVBLEN=7).
module tb_fdivsqrt_prenorm_seq;

    localparam int NF      = 52;
    localparam int DIVBLEN = 7;

    typedef struct {
        logic [NF:0] xm;
        logic [NF:0] ym;
        logic        sq;
        logic [NF:0] xn;
        logic [NF:0] yn;
        int          ell;
        int          m;
        logic        xz;
        logic        yz;
        int          k1;
        int          k4;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset, start, flush, Sqrt;
    logic [NF:0]        Xm, Ym;
    logic               busy, done;
    logic [NF:0]        XNorm, YNorm;
    logic [DIVBLEN-1:0] ell, m;
    logic               XZeroOut, YZeroOut;

    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    vec_t vecs[7];
    vec_t sb[$];
    logic [NF:0] one;

    fdivsqrt_prenorm_seq #(.NF(NF), .DIVBLEN(DIVBLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .Sqrt(Sqrt),
        .Xm(Xm), .Ym(Ym), .busy(busy), .done(done), .XNorm(XNorm), .YNorm(YNorm),
        .ell(ell), .m(m), .XZeroOut(XZeroOut), .YZeroOut(YZeroOut)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NF:0] xm, input logic [NF:0] ym, input logic sq,
                                input logic [NF:0] xn, input logic [NF:0] yn, input int e,
                                input int mm, input logic xz, input logic yz, input int k1,
                                input int k4);
        vec_t v;
        v.xm = xm; v.ym = ym; v.sq = sq; v.xn = xn; v.yn = yn; v.ell = e; v.m = mm;
        v.xz = xz; v.yz = yz; v.k1 = k1; v.k4 = k4;
        return v;
    endfunction

    function automatic int exp_k(input vec_t v);
`ifdef FDIVSQRT_PRENORM_SHIFT4_EN
        return v.k4;
`else
        return v.k1;
`endif
    endfunction

    // Called at posedge+1 with the DUT idle.
    task automatic run_vec(input int i, input bit hold);
        vec_t v, got;
        int   edges;
        int   d0;
        v  = vecs[i];
        d0 = done_cnt;
        Xm = v.xm; Ym = v.ym; Sqrt = v.sq; start = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        // Operands must have been captured; scramble the inputs.
        Xm = ~v.xm; Ym = ~v.ym; Sqrt = ~v.sq;
        chk($sformatf("v%0d_busy_after_start", i), 64'(busy), 64'd1);
        edges = 0;
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        if (done !== 1'b1) begin
            chk($sformatf("v%0d_done_timeout", i), 64'(done), 64'd1);
            void'(sb.pop_front());
        end else begin
            chk($sformatf("v%0d_latency", i), 64'(edges), 64'(exp_k(v) + 1));
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 64'd0, 64'd1);
            end else begin
                got = sb.pop_front();
                chk($sformatf("v%0d_XNorm", i), 64'(XNorm), 64'(got.xn));
                chk($sformatf("v%0d_YNorm", i), 64'(YNorm), 64'(got.yn));
                chk($sformatf("v%0d_ell", i), 64'(ell), 64'(got.ell));
                chk($sformatf("v%0d_m", i), 64'(m), 64'(got.m));
                chk($sformatf("v%0d_XZero", i), 64'(XZeroOut), 64'(got.xz));
                chk($sformatf("v%0d_YZero", i), 64'(YZeroOut), 64'(got.yz));
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_idle_after_done", i), {62'd0, busy, done}, 64'd0);
        if (hold) begin
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("v%0d_one_done_held_start", i), 64'(done_cnt - d0), 64'd1);
            chk($sformatf("v%0d_held_ell_kept", i), 64'(ell), 64'(v.ell));
        end
    endtask

    initial begin
        int d0;
        one = 1;
        //            Xm          Ym          Sq    XNorm       YNorm             ell m  xz    yz    k1  k4
        vecs[0] = mk(one << 52, (one << 52) | 5, 1'b0, one << 52, (one << 52) | 5, 0, 0, 1'b0, 1'b0, 0, 0);
        vecs[1] = mk(one << 52, one << 49, 1'b0, one << 52, one << 52, 0, 3, 1'b0, 1'b0, 3, 1);
        vecs[2] = mk(one, 53'd0, 1'b1, one << 52, one << 52, 52, 0, 1'b0, 1'b0, 52, 13);
        vecs[3] = mk(53'd0, 53'd0, 1'b0, 53'd0, 53'd0, 0, 0, 1'b1, 1'b1, 0, 0);
        vecs[4] = mk(one << 40, 53'd5, 1'b0, one << 52, 53'd5 << 50, 12, 50, 1'b0, 1'b0, 50, 13);
        vecs[5] = mk((one << 52) | 1, 53'd0, 1'b1, (one << 52) | 1, one << 52, 0, 0, 1'b0, 1'b0,
                     0, 0);
        vecs[6] = mk(53'd0, one << 51, 1'b0, 53'd0, one << 52, 0, 1, 1'b1, 1'b0, 1, 1);

        reset = 1'b0; start = 1'b0; flush = 1'b0; Sqrt = 1'b0; Xm = '0; Ym = '0;
        #2 reset = 1'b1;
        #2;
        chk("reset_ctrl", {62'd0, busy, done}, 64'd0);
        chk("reset_XNorm", 64'(XNorm), 64'd0);
        chk("reset_YNorm", 64'(YNorm), 64'd0);
        chk("reset_counts", {50'd0, ell, m}, 64'd0);
        chk("reset_zflags", {62'd0, XZeroOut, YZeroOut}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(i, 1'b0);

        // start held high across a whole operation
        run_vec(4, 1'b1);

        // flush in the 5th NORM cycle of the Xm=1 case
        d0 = done_cnt;
        Xm = vecs[2].xm; Ym = vecs[2].ym; Sqrt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", {62'd0, busy, done}, 64'd0);
        // flush beats a simultaneous start
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_beats_start", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
        run_vec(1, 1'b0);

        // asynchronous reset mid-NORM
        Xm = vecs[2].xm; Ym = '0; Sqrt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_ell_moving", 64'(ell != 0), 64'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_ctrl", {62'd0, busy, done}, 64'd0);
        chk("async_reset_data", {11'd0, XNorm} | {11'd0, YNorm}, 64'd0);
        chk("async_reset_counts", {48'd0, ell, m, XZeroOut, YZeroOut}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_vec(6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
